// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the 7-segment scan scheduler.
// Segment patterns are active-low: bit7 = dp, [6:0] = gfedcba.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic       blank;
        logic       dp;
        logic [3:0] bcd;
    } buf_entry_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam buf_entry_t ENTRY_RESET = '{blank: 1'b1, dp: 1'b0, bcd: 4'd0};

    localparam logic [7:0] SEG_DIGIT_0 = 8'hC0;
    localparam logic [7:0] SEG_DIGIT_1 = 8'hF9;
    localparam logic [7:0] SEG_DIGIT_2 = 8'hA4;
    localparam logic [7:0] SEG_DIGIT_3 = 8'hB0;
    localparam logic [7:0] SEG_DIGIT_4 = 8'h99;
    localparam logic [7:0] SEG_DIGIT_5 = 8'h92;
    localparam logic [7:0] SEG_DIGIT_6 = 8'h82;
    localparam logic [7:0] SEG_DIGIT_7 = 8'hF8;
    localparam logic [7:0] SEG_DIGIT_8 = 8'h80;
    localparam logic [7:0] SEG_DIGIT_9 = 8'h90;

    localparam logic [7:0] SEG_HEX_A = 8'h88;
    localparam logic [7:0] SEG_HEX_B = 8'h83;
    localparam logic [7:0] SEG_HEX_C = 8'hC6;
    localparam logic [7:0] SEG_HEX_D = 8'hA1;
    localparam logic [7:0] SEG_HEX_E = 8'h86;
    localparam logic [7:0] SEG_HEX_F = 8'h8E;

    // The decimal point is an independent active-low segment on top of the glyph.
    function automatic logic [7:0] apply_dp(input logic [7:0] glyph, input logic dp);
        return {glyph[7] & ~dp, glyph[6:0]};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational buffer-entry to segment-pattern decoder.
// Build option SEG7_HEX_EN: codes 10..15 show A,b,C,d,E,F instead of blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  buf_entry_t  entry_i,
    output logic [7:0]  seg_o
);

    logic [7:0] glyph_s;

    // Glyph lookup for the BCD (or hex) code
    always_comb begin
        glyph_s = SEG_BLANK;
        case (entry_i.bcd)
            4'd0:    glyph_s = SEG_DIGIT_0;
            4'd1:    glyph_s = SEG_DIGIT_1;
            4'd2:    glyph_s = SEG_DIGIT_2;
            4'd3:    glyph_s = SEG_DIGIT_3;
            4'd4:    glyph_s = SEG_DIGIT_4;
            4'd5:    glyph_s = SEG_DIGIT_5;
            4'd6:    glyph_s = SEG_DIGIT_6;
            4'd7:    glyph_s = SEG_DIGIT_7;
            4'd8:    glyph_s = SEG_DIGIT_8;
            4'd9:    glyph_s = SEG_DIGIT_9;
`ifdef SEG7_HEX_EN
            4'd10:   glyph_s = SEG_HEX_A;
            4'd11:   glyph_s = SEG_HEX_B;
            4'd12:   glyph_s = SEG_HEX_C;
            4'd13:   glyph_s = SEG_HEX_D;
            4'd14:   glyph_s = SEG_HEX_E;
            4'd15:   glyph_s = SEG_HEX_F;
`endif
            default: glyph_s = SEG_BLANK;
        endcase
    end

    // A blanked entry suppresses the decimal point as well
    always_comb begin
        if (entry_i.blank) begin
            seg_o = SEG_BLANK;
        end else begin
            seg_o = apply_dp(glyph_s, entry_i.dp);
        end
    end

endmodule

// File: rtl/seg7_scan_scheduler.sv
// Multiplexed common-anode 7-segment scan controller with tear-free double-buffered digits.
// Build option SEG7_HEX_EN (handled in seg7_decode) enables hex glyphs for codes 10..15.
module seg7_scan_scheduler
    import seg7_pkg::*;
#(
    parameter int CLK_FREQ     = 125_000_000,
    parameter int SCAN_FREQ    = 1000,
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [2:0]                    brightness,
    input  logic                          upd_valid,
    output logic                          upd_ready,
    input  logic [$clog2(NUM_DIGITS)-1:0] upd_digit,
    input  logic [3:0]                    upd_bcd,
    input  logic                          upd_dp,
    output logic [7:0]                    seg_out,
    output logic [NUM_DIGITS-1:0]         an_out,
    output logic [$clog2(NUM_DIGITS)-1:0] cur_digit,
    output logic                          frame_done
);

    localparam int SLOT_CYCLES  = CLK_FREQ / SCAN_FREQ;
    localparam int DRIVE_CYCLES = SLOT_CYCLES - BLANK_CYCLES;
    localparam int PWM_STEP     = DRIVE_CYCLES / 8;
    localparam int CNT_W        = $clog2(SLOT_CYCLES);
    localparam int DIG_W        = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
    localparam logic [DIG_W-1:0] DIGIT_LAST = DIG_W'(NUM_DIGITS - 1);

    scan_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIG_W-1:0]      digit_q, digit_d;
    logic [2:0]            bright_q;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]            seg_q, seg_d;
    logic                  frame_done_q, frame_done_d;
    logic                  upd_ready_q, upd_ready_d;

    buf_entry_t            shadow_q [NUM_DIGITS];
    buf_entry_t            active_q [NUM_DIGITS];

    logic [2:0]            bright_eff_s;
    logic [CNT_W-1:0]      on_cycles_s;
    logic                  upd_fire_s;
    buf_entry_t            entry_s;
    logic [7:0]            dec_seg_s;

    // Slot FSM: enable drop wins from any state; digit wrap raises frame_done
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        digit_d      = digit_q;
        frame_done_d = 1'b0;
        upd_ready_d  = 1'b1;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            digit_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    digit_d = '0;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (digit_q == DIGIT_LAST) begin
                            digit_d      = '0;
                            frame_done_d = 1'b1;
                            upd_ready_d  = 1'b0;
                        end else begin
                            digit_d = digit_q + DIG_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    digit_d = '0;
                end
            endcase
        end
    end

    // Brightness is latched on the first BLANK cycle; bypass lets a 1-cycle blank still use it
    always_comb begin
        if (state_q == BLANK && cnt_q == '0) begin
            bright_eff_s = brightness;
        end else begin
            bright_eff_s = bright_q;
        end
        if (bright_eff_s == 3'd7) begin
            on_cycles_s = CNT_W'(DRIVE_CYCLES);
        end else begin
            on_cycles_s = CNT_W'(({29'd0, bright_eff_s} + 32'd1) * 32'(PWM_STEP));
        end
    end

    // Pick the entry for the upcoming slot, seeing a commit that lands this cycle
    always_comb begin
        if (frame_done_q) begin
            entry_s = shadow_q[digit_d];
        end else begin
            entry_s = active_q[digit_d];
        end
    end

    seg7_decode u_decode (
        .entry_i (entry_s),
        .seg_o   (dec_seg_s)
    );

    // Output values are derived from next state so the anode drops on the first DRIVE cycle
    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        if (state_d == DRIVE) begin
            seg_d = dec_seg_s;
            if (cnt_d < on_cycles_s) begin
                an_d[digit_d] = 1'b0;
            end else begin
                an_d = '1;
            end
        end else begin
            seg_d = SEG_BLANK;
        end
    end

    assign upd_fire_s = upd_valid && upd_ready_q && (int'(upd_digit) < NUM_DIGITS);

    // FSM, counters and registered pin drivers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            digit_q      <= '0;
            bright_q     <= 3'd0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
            upd_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            bright_q     <= bright_eff_s;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            upd_ready_q  <= upd_ready_d;
        end
    end

    // Double buffer: requesters write shadow, shadow is copied to active while ready is low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= ENTRY_RESET;
                active_q[i] <= ENTRY_RESET;
            end
        end else begin
            if (upd_fire_s) begin
                shadow_q[upd_digit] <= '{blank: 1'b0, dp: upd_dp, bcd: upd_bcd};
            end
            if (frame_done_q) begin
                active_q <= shadow_q;
            end
        end
    end

    assign upd_ready  = upd_ready_q;
    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign cur_digit  = digit_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Self-checking bench for seg7_scan_scheduler: position-based frame model plus directed literal checks.
module tb_seg7_scan_scheduler;

    localparam int ND   = 4;
    localparam int SLOT = 100;
    localparam int BLK  = 4;
    localparam int WIN  = 96;
    localparam int STP  = 12;
    localparam int FRM  = SLOT * ND;
`ifdef SEG7_HEX_EN
    localparam logic [7:0] EXP_HEX_B = 8'h83;
`else
    localparam logic [7:0] EXP_HEX_B = 8'hFF;
`endif

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [2:0] brightness;
    logic       upd_valid;
    logic       upd_ready;
    logic [1:0] upd_digit;
    logic [3:0] upd_bcd;
    logic       upd_dp;
    logic [7:0] seg_out;
    logic [3:0] an_out;
    logic [1:0] cur_digit;
    logic       frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    seg7_scan_scheduler #(
        .CLK_FREQ     (1000),
        .SCAN_FREQ    (10),
        .NUM_DIGITS   (ND),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .brightness (brightness),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_digit  (upd_digit),
        .upd_bcd    (upd_bcd),
        .upd_dp     (upd_dp),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .cur_digit  (cur_digit),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference glyph table and display model state
    logic [7:0] glyph [16];
    logic [5:0] m_sh [ND];
    logic [5:0] m_ac [ND];
    bit         m_run = 1'b0;
    int         m_pos = 0;
    int         m_bright = 0;

    initial begin
        glyph[0] = 8'hC0; glyph[1] = 8'hF9; glyph[2] = 8'hA4; glyph[3] = 8'hB0;
        glyph[4] = 8'h99; glyph[5] = 8'h92; glyph[6] = 8'h82; glyph[7] = 8'hF8;
        glyph[8] = 8'h80; glyph[9] = 8'h90;
`ifdef SEG7_HEX_EN
        glyph[10] = 8'h88; glyph[11] = 8'h83; glyph[12] = 8'hC6;
        glyph[13] = 8'hA1; glyph[14] = 8'h86; glyph[15] = 8'h8E;
`else
        for (int i = 10; i < 16; i++) glyph[i] = 8'hFF;
`endif
    end

    function automatic logic [7:0] model_seg(input logic [5:0] e);
        logic [7:0] p;
        if (e[5]) return 8'hFF;
        p = glyph[e[3:0]];
        if (e[4]) p[7] = 1'b0;
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every-cycle compare: expected outputs follow from the position within the scan
    always @(negedge clk) begin
        int slot;
        int off;
        int on_len;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        logic [1:0] e_cur;
        logic       e_fd;
        if (!reset_n) begin
            m_run = 1'b0;
            m_pos = 0;
            for (int i = 0; i < ND; i++) begin
                m_sh[i] = 6'b100000;
                m_ac[i] = 6'b100000;
            end
        end
        e_an = 4'hF; e_seg = 8'hFF; e_cur = 2'd0; e_fd = 1'b0;
        if (m_run) begin
            slot  = (m_pos / SLOT) % ND;
            off   = m_pos % SLOT;
            e_cur = 2'(slot);
            e_fd  = (m_pos > 0) && (m_pos % FRM == 0);
            if (off == 0) m_bright = int'(brightness);
            if (off >= BLK) begin
                on_len = (m_bright == 7) ? WIN : (m_bright + 1) * STP;
                if (off - BLK < on_len) e_an = ~(4'b0001 << slot);
                e_seg = model_seg(m_ac[slot]);
            end
        end
        check("m_an_out", an_out, e_an);
        check("m_seg_out", seg_out, e_seg);
        check("m_cur_digit", cur_digit, e_cur);
        check("m_frame_done", frame_done, e_fd);
        check("m_upd_ready", upd_ready, !e_fd);
        if (reset_n) begin
            if (e_fd) begin
                for (int i = 0; i < ND; i++) m_ac[i] = m_sh[i];
            end
            if (upd_valid && !e_fd && int'(upd_digit) < ND)
                m_sh[upd_digit] = {1'b0, upd_dp, upd_bcd};
            if (!enable) m_run = 1'b0;
            else if (!m_run) begin m_run = 1'b1; m_pos = 0; end
            else m_pos++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        step();
        while (frame_done !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        check("frame_done_wait", frame_done, 1'b1);
    endtask

    task automatic write_digit(input logic [1:0] d, input logic [3:0] v, input logic dp);
        upd_valid = 1'b1; upd_digit = d; upd_bcd = v; upd_dp = dp;
        step();
        upd_valid = 1'b0;
    endtask

    task automatic count_slot(input int change_at, input logic [2:0] newb, output int cnt);
        cnt = 0;
        for (int i = 0; i < SLOT; i++) begin
            if (i == change_at) brightness = newb;
            if (an_out != 4'hF) cnt++;
            step();
        end
    endtask

    initial begin
        logic [3:0] an_seq [ND];
        int t0;
        int lit;
        an_seq[0] = 4'b1110; an_seq[1] = 4'b1101; an_seq[2] = 4'b1011; an_seq[3] = 4'b0111;
        reset_n = 1'b0; enable = 1'b0; brightness = 3'd7;
        upd_valid = 1'b0; upd_digit = 2'd0; upd_bcd = 4'd0; upd_dp = 1'b0;
        repeat (3) step();
        check("rst_an", an_out, 4'hF);
        check("rst_seg", seg_out, 8'hFF);
        check("rst_ready", upd_ready, 1'b1);
        check("rst_fd", frame_done, 1'b0);
        reset_n = 1'b1; enable = 1'b1;

        // Free-running scan with blank buffers
        wait_fd();
        t0 = cyc;
        wait_fd();
        check("frame_period", cyc - t0, FRM);
        repeat (50) step();
        for (int s = 0; s < ND; s++) begin
            check("an_sequence", an_out, an_seq[s]);
            check("cur_sequence", cur_digit, s);
            check("seg_blank", seg_out, 8'hFF);
            repeat (SLOT) step();
        end

        // Mid-frame writes only appear after the next commit
        wait_fd();
        repeat (150) step();
        write_digit(2'd2, 4'd7, 1'b1);
        write_digit(2'd1, 4'd3, 1'b0);
        write_digit(2'd1, 4'd5, 1'b0);
        repeat (97) step();
        check("seg_before_commit", seg_out, 8'hFF);
        wait_fd();
        check("ready_low_at_commit", upd_ready, 1'b0);
        repeat (150) step();
        check("seg_last_wins", seg_out, 8'h92);
        repeat (100) step();
        check("seg_7_dp", seg_out, 8'h78);
        check("an_digit2", an_out, 4'b1011);

        // PWM duty per slot, mid-slot change deferred
        wait_fd();
        brightness = 3'd0;
        count_slot(-1, 3'd0, lit);
        check("pwm_b0", lit, 12);
        brightness = 3'd3;
        count_slot(-1, 3'd3, lit);
        check("pwm_b3", lit, 48);
        count_slot(30, 3'd7, lit);
        check("pwm_mid_change", lit, 48);
        count_slot(-1, 3'd7, lit);
        check("pwm_b7", lit, 96);

        // Hex code on digit 0
        step();
        write_digit(2'd0, 4'hB, 1'b0);
        wait_fd();
        repeat (50) step();
        check("seg_hex_b", seg_out, EXP_HEX_B);
        check("an_digit0", an_out, 4'b1110);

        // Disable during DRIVE of digit 1, then resume
        wait_fd();
        repeat (150) step();
        enable = 1'b0;
        step();
        check("dis_an", an_out, 4'hF);
        check("dis_seg", seg_out, 8'hFF);
        check("dis_cur", cur_digit, 2'd0);
        check("dis_fd", frame_done, 1'b0);
        repeat (20) step();
        enable = 1'b1;
        repeat (4) step();
        check("reen_blank", an_out, 4'hF);
        step();
        check("reen_drive", an_out, 4'b1110);
        check("reen_cur", cur_digit, 2'd0);

        // Async reset mid-DRIVE clears buffers
        wait_fd();
        repeat (250) step();
        check("pre_reset_seg", seg_out, 8'h78);
        reset_n = 1'b0;
        #1;
        check("async_rst_an", an_out, 4'hF);
        check("async_rst_seg", seg_out, 8'hFF);
        check("async_rst_ready", upd_ready, 1'b1);
        check("async_rst_cur", cur_digit, 2'd0);
        repeat (3) step();
        reset_n = 1'b1;
        wait_fd();
        repeat (50) step();
        check("post_rst_d0", seg_out, 8'hFF);
        repeat (200) step();
        check("post_rst_d2", seg_out, 8'hFF);
        check("post_rst_an", an_out, 4'b1011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
